// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle combinational lookup, one-cycle update visibility.
// No backpressure: one lookup and one update accepted every cycle; stats counters saturate.
module branch_target_buffer #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 32,
  localparam int IDX_BITS  = $clog2(ENTRIES)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] LookupPC,
  output logic                  PredTaken,
  output logic [ADDR_WIDTH-1:0] PredTarget,
  input  logic                  UpdateEn,
  input  logic [ADDR_WIDTH-1:0] UpdatePC,
  input  logic                  UpdateTaken,
  input  logic [ADDR_WIDTH-1:0] UpdateTarget,
  input  logic                  UpdatePredTaken,
  output logic                  Mispredict,
  output logic [31:0]           UpdateCount,
  output logic [31:0]           MispredictCount
);

  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;

  logic                  validQ  [ENTRIES];
  logic [TAG_BITS-1:0]   tagQ    [ENTRIES];
  logic [ADDR_WIDTH-1:0] targetQ [ENTRIES];
  logic [1:0]            ctrQ    [ENTRIES];

  logic [IDX_BITS-1:0] lookupIdx;
  logic [IDX_BITS-1:0] updateIdx;
  logic [TAG_BITS-1:0] lookupTag;
  logic [TAG_BITS-1:0] updateTag;
  logic                lookupHit;
  logic                updateHit;
  logic                dirWrong;
  logic                unusedPcLsbs;

  // Instructions are word aligned, so the byte-offset bits carry no information.
  assign unusedPcLsbs = ^{LookupPC[1:0], UpdatePC[1:0]};

  assign lookupIdx = LookupPC[IDX_BITS+1:2];
  assign lookupTag = LookupPC[ADDR_WIDTH-1:IDX_BITS+2];
  assign updateIdx = UpdatePC[IDX_BITS+1:2];
  assign updateTag = UpdatePC[ADDR_WIDTH-1:IDX_BITS+2];

  assign lookupHit = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
  assign updateHit = validQ[updateIdx] && (tagQ[updateIdx] == updateTag);
  assign dirWrong  = UpdatePredTaken != UpdateTaken;

  assign PredTaken  = lookupHit && ctrQ[lookupIdx][1];
  assign PredTarget = PredTaken ? targetQ[lookupIdx] : LookupPC + ADDR_WIDTH'(4);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= 2'd1;
      end
    end else if (UpdateEn) begin
      if (updateHit) begin
        if (UpdateTaken && ctrQ[updateIdx] != 2'd3)
          ctrQ[updateIdx] <= ctrQ[updateIdx] + 2'd1;
        else if (!UpdateTaken && ctrQ[updateIdx] != 2'd0)
          ctrQ[updateIdx] <= ctrQ[updateIdx] - 2'd1;
      end else if (UpdateTaken) begin
        validQ[updateIdx] <= 1'b1;
        ctrQ[updateIdx]   <= 2'd2;
      end
    end
  end

  // On a hit the tag rewrite is a no-op; on a taken miss it performs the allocation.
  always_ff @(posedge Clk) begin
    if (!Rst && UpdateEn && UpdateTaken) begin
      tagQ[updateIdx]    <= updateTag;
      targetQ[updateIdx] <= UpdateTarget;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Mispredict      <= 1'b0;
      UpdateCount     <= 32'd0;
      MispredictCount <= 32'd0;
    end else begin
      Mispredict <= UpdateEn && dirWrong;
      if (UpdateEn && UpdateCount != 32'hFFFF_FFFF)
        UpdateCount <= UpdateCount + 32'd1;
      if (UpdateEn && dirWrong && MispredictCount != 32'hFFFF_FFFF)
        MispredictCount <= MispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios then random traffic vs. an array model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] LookupPC = '0;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        UpdateEn = 1'b0;
  logic [31:0] UpdatePC = '0;
  logic        UpdateTaken = 1'b0;
  logic [31:0] UpdateTarget = '0;
  logic        UpdatePredTaken = 1'b0;
  logic        Mispredict;
  logic [31:0] UpdateCount;
  logic [31:0] MispredictCount;

  branch_target_buffer #(.ENTRIES(ENTRIES), .ADDR_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .LookupPC(LookupPC), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .UpdateEn(UpdateEn), .UpdatePC(UpdatePC), .UpdateTaken(UpdateTaken),
    .UpdateTarget(UpdateTarget), .UpdatePredTaken(UpdatePredTaken), .Mispredict(Mispredict),
    .UpdateCount(UpdateCount), .MispredictCount(MispredictCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] uc;
    logic [31:0] mc;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays indexed by word address modulo table size.
  bit          mInit = 0;
  bit          mValid [ENTRIES];
  logic [31:0] mTag   [ENTRIES];
  logic [31:0] mTarget[ENTRIES];
  int          mCtr   [ENTRIES];
  bit          mMisp;
  longint      mUpd, mMis;

  function automatic int idxOf(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tagOf(logic [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return mValid[idxOf(pc)] && mTag[idxOf(pc)] == tagOf(pc);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cycle(input bit rst, input bit upEn, input logic [31:0] upPC, input bit upTaken,
                       input logic [31:0] upTgt, input bit upPred, input logic [31:0] lookPC);
    exp_t e;
    int   i;
    bit   pt;
    @(negedge Clk);
    Rst = rst; UpdateEn = upEn; UpdatePC = upPC; UpdateTaken = upTaken;
    UpdateTarget = upTgt; UpdatePredTaken = upPred; LookupPC = lookPC;
    if (mInit) begin
      i = idxOf(lookPC);
      pt = modelHit(lookPC) && mCtr[i] >= 2;
      e.pt = pt;
      e.tgt = pt ? mTarget[i] : lookPC + 32'd4;
      e.mp = mMisp;
      e.uc = 32'(mUpd);
      e.mc = 32'(mMis);
      expQ.push_back(e);
    end
    // Apply the rising edge to the model.
    if (rst) begin
      mInit = 1;
      foreach (mValid[k]) begin mValid[k] = 0; mCtr[k] = 1; end
      mMisp = 0; mUpd = 0; mMis = 0;
    end else if (upEn) begin
      i = idxOf(upPC);
      if (modelHit(upPC)) begin
        mCtr[i] = upTaken ? (mCtr[i] < 3 ? mCtr[i] + 1 : 3) : (mCtr[i] > 0 ? mCtr[i] - 1 : 0);
        if (upTaken) mTarget[i] = upTgt;
      end else if (upTaken) begin
        mValid[i] = 1; mTag[i] = tagOf(upPC); mTarget[i] = upTgt; mCtr[i] = 2;
      end
      mMisp = (upPred != upTaken);
      if (mUpd < 64'hFFFF_FFFF) mUpd++;
      if (mMisp && mMis < 64'hFFFF_FFFF) mMis++;
    end else begin
      mMisp = 0;
    end
  endtask

  task automatic idle(input logic [31:0] lookPC);
    cycle(0, 0, 32'h0, 0, 32'h0, 0, lookPC);
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit pred);
    cycle(0, 1, pc, taken, tgt, pred, pc);
  endtask

  // Monitor: every cycle is an output beat; compare once inputs have settled.
  always @(negedge Clk) begin
    exp_t e;
    #2;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("sb_predTaken", {31'b0, PredTaken}, {31'b0, e.pt});
      chk("sb_predTarget", PredTarget, e.tgt);
      chk("sb_mispredict", {31'b0, Mispredict}, {31'b0, e.mp});
      chk("sb_updateCount", UpdateCount, e.uc);
      chk("sb_mispredictCount", MispredictCount, e.mc);
    end
  end

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0050;

  initial begin
    int waitCycles;
    logic [31:0] pc, tgt;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);

    idle(PC_A); #3;
    chk("rst_predTaken", {31'b0, PredTaken}, 32'd0);
    chk("rst_predTarget", PredTarget, 32'h0040_0014);
    chk("rst_updateCount", UpdateCount, 32'd0);
    chk("rst_mispredictCount", MispredictCount, 32'd0);

    // Allocate while looking up the same index: old contents this cycle.
    cycle(0, 1, PC_A, 1, 32'h0040_0100, 0, PC_A); #3;
    chk("sameCycle_predTaken", {31'b0, PredTaken}, 32'd0);
    idle(PC_A); #3;
    chk("alloc_predTaken", {31'b0, PredTaken}, 32'd1);
    chk("alloc_predTarget", PredTarget, 32'h0040_0100);
    chk("alloc_mispredict", {31'b0, Mispredict}, 32'd1);
    chk("alloc_mispredictCount", MispredictCount, 32'd1);

    upd(PC_A, 0, 0, 1);
    upd(PC_A, 0, 0, 0);
    idle(PC_A); #3;
    chk("ctr0_predTaken", {31'b0, PredTaken}, 32'd0);
    chk("ctr0_predTarget", PredTarget, 32'h0040_0014);
    for (int k = 0; k < 4; k++) upd(PC_A, 1, 32'h0040_0100, 0);
    upd(PC_A, 0, 0, 1);
    idle(PC_A); #3;
    chk("sat_predTaken", {31'b0, PredTaken}, 32'd1);
    chk("sat_updateCount", UpdateCount, 32'd8);

    upd(PC_B, 1, 32'h0040_0200, 0);
    idle(PC_A); #3;
    chk("alias_old_predTaken", {31'b0, PredTaken}, 32'd0);
    idle(PC_B); #3;
    chk("alias_new_predTaken", {31'b0, PredTaken}, 32'd1);
    chk("alias_new_predTarget", PredTarget, 32'h0040_0200);

    upd(32'h0040_0020, 1, 32'h0040_0300, 0);
    upd(32'h0040_0030, 1, 32'h0040_0400, 0);
    cycle(1, 1, 32'h0040_0040, 1, 32'h0040_0500, 0, PC_B);
    idle(32'h0040_0040); #3;
    chk("rstUpd_predTaken", {31'b0, PredTaken}, 32'd0);
    chk("rstUpd_updateCount", UpdateCount, 32'd0);
    chk("rstUpd_mispredictCount", MispredictCount, 32'd0);
    idle(32'h0040_0020); #3;
    chk("rstUpd_predTarget", PredTarget, 32'h0040_0024);
    idle(PC_B);

    for (int n = 0; n < 3000; n++) begin
      pc  = 32'h0040_0000 | (32'($urandom_range(0, 47)) << 2);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) pc = $urandom;
      if ($urandom_range(0, 299) == 0)
        cycle(1, $urandom_range(0, 1), pc, 1, tgt, 0, pc);
      else
        cycle(0, $urandom_range(0, 2) != 0, pc, $urandom_range(0, 2) != 0, tgt,
              $urandom_range(0, 1), 32'h0040_0000 | (32'($urandom_range(0, 47)) << 2));
    end
    idle(PC_A);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge Clk);
      waitCycles++;
    end
    #4;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
